// File: rtl/br_tag_pkg.sv
// rtl/br_tag_pkg.sv - shared branch tag sizes and types
package br_tag_pkg;
  localparam int N_BR_TAGS = 4;
  localparam int BR_TAG_W  = $clog2(N_BR_TAGS);

  typedef logic [BR_TAG_W-1:0]  br_tag_t;
  typedef logic [N_BR_TAGS-1:0] br_mask_t;
endpackage

// File: rtl/br_free_finder.sv
// rtl/br_free_finder.sv - lowest-set-bit priority encoder with found flag
module br_free_finder #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] free_i,
  output logic [W-1:0] idx_o,
  output logic         found_o
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (free_i[i]) begin
        idx_o   = W'(i);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/branch_tag_manager.sv
// rtl/branch_tag_manager.sv - branch tag allocator with dependency-row squash;
// optional protocol checker under BR_TAG_ERR_CHECK_EN.
module branch_tag_manager
  import br_tag_pkg::*;
#(
  parameter int NUM_TAGS = N_BR_TAGS
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        alloc_req,
  output logic                        alloc_gnt,
  output logic [$clog2(NUM_TAGS)-1:0] alloc_tag,
  output logic [NUM_TAGS-1:0]         alloc_mask,
  input  logic                        resolve_valid,
  input  logic [$clog2(NUM_TAGS)-1:0] resolve_tag,
  input  logic                        take_branch,
  output logic                        kill,
  output logic [NUM_TAGS-1:0]         kill_mask,
  output logic                        resolve,
  output logic [NUM_TAGS-1:0]         free_mask,
  output logic [NUM_TAGS-1:0]         active_mask,
  output logic                        branch_pending,
  output logic                        full,
  output logic                        err
);

  localparam int TW = $clog2(NUM_TAGS);

  logic [NUM_TAGS-1:0] valid_q, valid_d;
  logic [NUM_TAGS-1:0] dep_q [NUM_TAGS];
  logic [NUM_TAGS-1:0] dep_d [NUM_TAGS];
  logic                kill_q, kill_d;
  logic                resolve_q, resolve_d;
  logic [NUM_TAGS-1:0] kill_mask_q, kill_mask_d;
  logic [NUM_TAGS-1:0] free_mask_q, free_mask_d;

  logic [NUM_TAGS-1:0] res_onehot;
  logic [NUM_TAGS-1:0] squash_mask;
  logic                res_hit, res_ok, res_bad;
  logic [TW-1:0]       free_tag;
  logic                free_found;

  br_free_finder #(
    .N(NUM_TAGS),
    .W(TW)
  ) u_free_finder (
    .free_i (~valid_q),
    .idx_o  (free_tag),
    .found_o(free_found)
  );

  assign res_onehot = NUM_TAGS'(1) << resolve_tag;
  assign res_hit    = resolve_valid & valid_q[resolve_tag];
  assign res_ok     = res_hit & ~take_branch;
  assign res_bad    = res_hit & take_branch;

  // A mispredict squashes the branch itself plus every tag younger than it.
  always_comb begin
    squash_mask = res_onehot;
    for (int j = 0; j < NUM_TAGS; j++) begin
      if (valid_q[j] && dep_q[j][resolve_tag]) squash_mask[j] = 1'b1;
    end
  end

  assign alloc_gnt  = alloc_req & free_found & ~(resolve_valid & take_branch) & ~kill_q;
  assign alloc_tag  = free_tag;
  assign alloc_mask = valid_q & ~(res_ok ? res_onehot : '0);

  always_comb begin
    valid_d = valid_q;
    dep_d   = dep_q;
    if (res_ok) begin
      valid_d = valid_d & ~res_onehot;
      for (int j = 0; j < NUM_TAGS; j++) dep_d[j][resolve_tag] = 1'b0;
    end
    if (res_bad) begin
      valid_d = valid_d & ~squash_mask;
      for (int j = 0; j < NUM_TAGS; j++) begin
        if (squash_mask[j]) dep_d[j] = '0;
      end
    end
    if (alloc_gnt) begin
      valid_d[free_tag] = 1'b1;
      dep_d[free_tag]   = alloc_mask;
    end
    kill_d      = res_bad;
    resolve_d   = res_ok;
    kill_mask_d = res_bad ? squash_mask : '0;
    free_mask_d = res_ok ? res_onehot : kill_mask_d;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q     <= '0;
      kill_q      <= 1'b0;
      resolve_q   <= 1'b0;
      kill_mask_q <= '0;
      free_mask_q <= '0;
      for (int j = 0; j < NUM_TAGS; j++) dep_q[j] <= '0;
    end else begin
      valid_q     <= valid_d;
      kill_q      <= kill_d;
      resolve_q   <= resolve_d;
      kill_mask_q <= kill_mask_d;
      free_mask_q <= free_mask_d;
      for (int j = 0; j < NUM_TAGS; j++) dep_q[j] <= dep_d[j];
    end
  end

  assign kill           = kill_q;
  assign resolve        = resolve_q;
  assign kill_mask      = kill_mask_q;
  assign free_mask      = free_mask_q;
  assign active_mask    = valid_q;
  assign branch_pending = |valid_q;
  assign full           = &valid_q;

`ifdef BR_TAG_ERR_CHECK_EN
  logic       err_q, err_d;
  logic [6:0] stall_cnt_q, stall_cnt_d;
  logic       stall;

  // Counter saturates at 64; a stall seen with the counter there is the 65th cycle.
  assign stall = alloc_req & ~free_found;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    err_d       = err_q;
    if (!stall) stall_cnt_d = '0;
    else if (stall_cnt_q != 7'd64) stall_cnt_d = stall_cnt_q + 7'd1;
    if ((resolve_valid && !valid_q[resolve_tag]) || (stall && stall_cnt_q == 7'd64)) err_d = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_q       <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      err_q       <= err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_branch_tag_manager.sv
// tb/tb_branch_tag_manager.sv - vector table, corner sequences and random run against an age-ordered list model
module tb_branch_tag_manager;
  import br_tag_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       alloc_req = 1'b0;
  logic       alloc_gnt;
  br_tag_t    alloc_tag;
  br_mask_t   alloc_mask;
  logic       resolve_valid = 1'b0;
  br_tag_t    resolve_tag = '0;
  logic       take_branch = 1'b0;
  logic       kill, resolve, branch_pending, full, err;
  br_mask_t   kill_mask, free_mask, active_mask;

  branch_tag_manager #(.NUM_TAGS(N_BR_TAGS)) dut (
    .clock(clock), .reset(reset),
    .alloc_req(alloc_req), .alloc_gnt(alloc_gnt), .alloc_tag(alloc_tag), .alloc_mask(alloc_mask),
    .resolve_valid(resolve_valid), .resolve_tag(resolve_tag), .take_branch(take_branch),
    .kill(kill), .kill_mask(kill_mask), .resolve(resolve), .free_mask(free_mask),
    .active_mask(active_mask), .branch_pending(branch_pending), .full(full), .err(err)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Model: outstanding tags kept in allocation order; anything later in the list is younger.
  bit  mv [4];
  int  order [$];
  bit  m_kill, m_res, m_err;
  int  m_kmask, m_free, m_stall;
  bit  g_gnt;
  int  g_tag, g_amask;

  function automatic int vmask();
    int m = 0;
    for (int i = 0; i < 4; i++) if (mv[i]) m |= (1 << i);
    return m;
  endfunction

  task automatic check_regs(input string pfx);
    chk({pfx, "_kill"}, int'(kill), int'(m_kill));
    chk({pfx, "_resolve"}, int'(resolve), int'(m_res));
    chk({pfx, "_kill_mask"}, int'(kill_mask), m_kmask);
    chk({pfx, "_free_mask"}, int'(free_mask), m_free);
    chk({pfx, "_active"}, int'(active_mask), vmask());
    chk({pfx, "_pending"}, int'(branch_pending), int'(vmask() != 0));
    chk({pfx, "_full"}, int'(full), int'(vmask() == 15));
    chk({pfx, "_err"}, int'(err), int'(m_err));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    alloc_req = 1'b0; resolve_valid = 1'b0; resolve_tag = '0; take_branch = 1'b0;
    for (int i = 0; i < 4; i++) mv[i] = 1'b0;
    order.delete();
    m_kill = 0; m_res = 0; m_err = 0; m_kmask = 0; m_free = 0; m_stall = 0;
    #2;
    check_regs("rst_async");
    @(negedge clock);
    reset = 1'b0;
    #1;
    check_regs("rst_rel");
  endtask

  // Called just after a negedge; returns just after the next negedge.
  task automatic step(input bit rq, input bit rv, input int rt, input bit tk);
    bit e_full, rhit, e_gnt;
    int e_tag, e_amask, p, sq;
    alloc_req = rq; resolve_valid = rv; resolve_tag = br_tag_t'(rt); take_branch = tk;
    #1;
    e_full  = (vmask() == 15);
    rhit    = rv && mv[rt];
    e_gnt   = rq && !e_full && !(rv && tk) && !m_kill;
    e_tag   = 0;
    for (int i = 3; i >= 0; i--) if (!mv[i]) e_tag = i;
    e_amask = vmask() & ~((rhit && !tk) ? (1 << rt) : 0);
    g_gnt = alloc_gnt; g_tag = int'(alloc_tag); g_amask = int'(alloc_mask);
    chk("alloc_gnt", int'(g_gnt), int'(e_gnt));
    if (e_gnt) begin
      chk("alloc_tag", g_tag, e_tag);
      chk("alloc_mask", g_amask, e_amask);
    end
    @(posedge clock);
`ifdef BR_TAG_ERR_CHECK_EN
    if (rv && !mv[rt]) m_err = 1;
    if (rq && e_full) begin
      m_stall++;
      if (m_stall > 64) m_err = 1;
    end else m_stall = 0;
`endif
    m_kill = 0; m_res = 0; m_kmask = 0; m_free = 0;
    if (rhit) begin
      p = 0;
      for (int k = 0; k < order.size(); k++) if (order[k] == rt) p = k;
      if (!tk) begin
        order.delete(p);
        mv[rt] = 0;
        m_res = 1; m_free = 1 << rt;
      end else begin
        sq = 0;
        while (order.size() > p) begin
          int t;
          t = order.pop_back();
          mv[t] = 0;
          sq |= (1 << t);
        end
        m_kill = 1; m_kmask = sq; m_free = sq;
      end
    end
    if (e_gnt) begin
      mv[e_tag] = 1;
      order.push_back(e_tag);
    end
    #1;
    check_regs("model");
    @(negedge clock);
  endtask

  typedef struct {
    bit rst; bit rq; bit rv; int rt; bit tk;
    bit gnt; int tag; int amask;
    bit kill; bit res; int kmask; int free; int active;
  } vec_t;

  vec_t vecs [$];

  function automatic vec_t mk(bit rst, bit rq, bit rv, int rt, bit tk, bit gnt, int tag, int amask,
                              bit kl, bit rs, int kmask, int free, int active);
    vec_t v;
    v.rst = rst; v.rq = rq; v.rv = rv; v.rt = rt; v.tk = tk;
    v.gnt = gnt; v.tag = tag; v.amask = amask;
    v.kill = kl; v.res = rs; v.kmask = kmask; v.free = free; v.active = active;
    return v;
  endfunction

  initial begin
    // fill four tags, fifth request stalls
    vecs.push_back(mk(1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 3));
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 2, 3, 0, 0, 0, 0, 7));
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 3, 7, 0, 0, 0, 0, 15));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 15));
    // correct resolve of tag 1 among 0..2
    vecs.push_back(mk(1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 3));
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 2, 3, 0, 0, 0, 0, 7));
    vecs.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 0, 2, 5));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5));
    // mispredict of tag 1 among 0..3
    vecs.push_back(mk(1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 3));
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 2, 3, 0, 0, 0, 0, 7));
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 3, 7, 0, 0, 0, 0, 15));
    vecs.push_back(mk(0, 0, 1, 1, 1, 0, 0, 0, 1, 0, 14, 14, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    // reset mid-operation, then grant plus correct resolve in the same cycle
    vecs.push_back(mk(1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 1, 0, 0, 1, 1, 0, 0, 1, 0, 1, 2));
    // alloc during mispredict and during the kill cycle
    vecs.push_back(mk(1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 3));
    vecs.push_back(mk(0, 1, 1, 0, 1, 0, 0, 0, 1, 0, 3, 3, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1));
    // resolve of an inactive tag
    vecs.push_back(mk(1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 3));
    vecs.push_back(mk(0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 3));

    @(negedge clock);
    do_reset();
    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      step(vecs[i].rq, vecs[i].rv, vecs[i].rt, vecs[i].tk);
      chk($sformatf("v%0d_gnt", i), int'(g_gnt), int'(vecs[i].gnt));
      if (vecs[i].gnt) begin
        chk($sformatf("v%0d_tag", i), g_tag, vecs[i].tag);
        chk($sformatf("v%0d_amask", i), g_amask, vecs[i].amask);
      end
      chk($sformatf("v%0d_kill", i), int'(kill), int'(vecs[i].kill));
      chk($sformatf("v%0d_resolve", i), int'(resolve), int'(vecs[i].res));
      chk($sformatf("v%0d_kmask", i), int'(kill_mask), vecs[i].kmask);
      chk($sformatf("v%0d_free", i), int'(free_mask), vecs[i].free);
      chk($sformatf("v%0d_active", i), int'(active_mask), vecs[i].active);
    end
`ifdef BR_TAG_ERR_CHECK_EN
    chk("inactive_resolve_err", int'(err), 1);
`else
    chk("inactive_resolve_err", int'(err), 0);
`endif

    // long stall while full, then drain
    do_reset();
    repeat (4) step(1, 0, 0, 0);
    repeat (70) step(1, 0, 0, 0);
    step(0, 1, 3, 0);
    step(1, 1, 0, 1);
    step(1, 0, 0, 0);

    // random traffic with occasional resets
    do_reset();
    repeat (600) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      step($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 5,
           int'($urandom_range(0, 3)), $urandom_range(0, 9) < 3);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_tag_manager.md
BRANCH_TAG_MANAGER -- requirements
Module: branch_tag_manager

Interface
REQ-001 SHALL have parameter: NUM_TAGS, default 4 (br_tag_pkg::N_BR_TAGS), number of concurrently outstanding branches.
REQ-002 SHALL have port: clock  input  1  rising-edge clock.
REQ-003 SHALL have port: reset  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: alloc_req  input  1  decode has a conditional branch needing a tag.
REQ-005 SHALL have port: alloc_gnt  output  1  tag granted this cycle (combinational).
REQ-006 SHALL have port: alloc_tag  output  $clog2(NUM_TAGS)  granted tag; valid when alloc_gnt.
REQ-007 SHALL have port: alloc_mask  output  NUM_TAGS  tags outstanding and older at grant; valid when alloc_gnt.
REQ-008 SHALL have port: resolve_valid  input  1  execute resolved a branch this cycle.
REQ-009 SHALL have port: resolve_tag  input  $clog2(NUM_TAGS)  tag of resolved branch.
REQ-010 SHALL have port: take_branch  input  1  branch taken; speculation is always not-taken, so 1 = mispredict.
REQ-011 SHALL have port: kill  output  1  registered one-cycle squash pulse.
REQ-012 SHALL have port: kill_mask  output  NUM_TAGS  registered; tags squashed, valid with kill.
REQ-013 SHALL have port: resolve  output  1  registered one-cycle correct-prediction pulse.
REQ-014 SHALL have port: free_mask  output  NUM_TAGS  registered; tags released, valid with kill or resolve.
REQ-015 SHALL have port: active_mask  output  NUM_TAGS  registered outstanding tags.
REQ-016 SHALL have port: branch_pending  output  1  |active_mask.
REQ-017 SHALL have port: full  output  1  &active_mask.
REQ-018 SHALL have port: err  output  1  sticky protocol error flag.

Function
REQ-019 SHALL hold per-tag valid bit and dependency row dep[t] (NUM_TAGS bits; tags older than t).
REQ-020 SHALL grant: alloc_gnt = alloc_req & !full & !(resolve_valid & take_branch) & !kill.
REQ-021 SHALL pick alloc_tag as lowest-index free tag; alloc_mask = active_mask less any tag resolved correctly this cycle.
REQ-022 SHALL on grant set valid[alloc_tag] and dep[alloc_tag] = alloc_mask at next edge.
REQ-023 SHALL on resolve_valid & !take_branch & valid[resolve_tag]: next cycle resolve=1, free_mask=onehot(resolve_tag); clear valid[resolve_tag] and column resolve_tag in every dep row.
REQ-024 SHALL on resolve_valid & take_branch & valid[resolve_tag]: next cycle kill=1, kill_mask=free_mask = onehot(resolve_tag) | {j: valid[j] & dep[j][resolve_tag]}; clear those valid bits and their dep rows.
REQ-025 SHALL, with correct resolve and grant same cycle, apply both; new dep row excludes resolved tag.
REQ-026 SHALL ignore resolve_valid for invalid resolve_tag (no pulse, no state change).
REQ-027 SHALL never assert kill and resolve together; one resolution per cycle maximum.
REQ-028 SHALL deassert kill, resolve, kill_mask, free_mask (all 0) in cycles without accepted resolution.
REQ-029 SHALL not grant while full; requester holds alloc_req (stall), no state change.
REQ-030 SHALL keep tag numbering unordered; age derives only from dep rows, so tag reuse/wrap-around is safe.

Reset
REQ-031 SHALL on reset clear all valid bits and dep rows; kill, resolve, kill_mask, free_mask, active_mask, err = 0; branch_pending = 0; full = 0.
REQ-032 SHALL, on reset mid-operation, drop outstanding tags with no kill/resolve pulse; first grant after release is tag 0.

Configuration
REQ-033 SHALL, with BR_TAG_ERR_CHECK_EN defined, set err (sticky until reset) on resolve_valid with invalid tag or alloc_req while full persists more than 64 consecutive cycles.
REQ-034 SHALL, without BR_TAG_ERR_CHECK_EN, tie err to 0 and synthesise no checker logic; all other behaviour identical.

Structure
REQ-035 SHALL place N_BR_TAGS, BR_TAG_W, typedefs br_tag_t and br_mask_t in shared package br_tag_pkg.
REQ-036 SHALL implement lowest-free-tag selection in sub-module br_free_finder (combinational lowest-set-bit priority encoder plus found flag).

Verification
REQ-037 SHALL cover: reset, alloc_req 4 cycles -> tags 0,1,2,3; alloc_masks 0000,0001,0011,0111; full=1; 5th req alloc_gnt=0.
REQ-038 SHALL cover: tags 0..2 active, resolve tag1 take_branch=0 -> next cycle resolve=1, free_mask=0010, active_mask=0101.
REQ-039 SHALL cover: tags 0..3 allocated in order, resolve tag1 take_branch=1 -> next cycle kill=1, kill_mask=1110, active_mask=0001.
REQ-040 SHALL cover: tag0 active, same cycle alloc_req and correct resolve of tag0 -> alloc_tag=1, alloc_mask=0000, active_mask=0010.
REQ-041 SHALL cover: same cycle alloc_req and mispredict resolve -> alloc_gnt=0 that cycle and kill cycle.
REQ-042 SHALL cover: resolve tag2 while inactive -> no pulse, state unchanged; err=1 only with BR_TAG_ERR_CHECK_EN.
